// File: rtl/rgb_stream_packer_if.sv
// rtl/rgb_stream_packer_if.sv - pixel input and packed 32-bit output stream bundle
interface rgb_stream_packer_if;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        first;
    logic        last_x;
    logic        last_y;
    logic        valid;
    logic        ready;
    logic [31:0] out_tdata;
    logic        out_tvalid;
    logic        out_tready;
    logic        out_tuser;
    logic        out_tlast;

    // master: renderer feeding pixels plus the downstream word consumer
    modport master (
        output r, g, b, first, last_x, last_y, valid, out_tready,
        input  ready, out_tdata, out_tvalid, out_tuser, out_tlast
    );

    // slave: the packer itself
    modport slave (
        input  r, g, b, first, last_x, last_y, valid, out_tready,
        output ready, out_tdata, out_tvalid, out_tuser, out_tlast
    );
endinterface

// File: rtl/rgb_stream_packer.sv
// rtl/rgb_stream_packer.sv - checks frame geometry and packs 4 RGB pixels into 3 words
module rgb_stream_packer #(
    parameter int FRAME_WIDTH      = 640,
    parameter int FRAME_HEIGHT     = 480,
    parameter int PIXEL_DATA_WIDTH = 10
) (
    input  logic                clk,
    input  logic                reset,
    rgb_stream_packer_if.slave  bus,
    output logic                frame_done,
    output logic                frame_err,
    output logic [7:0]          err_count
);
    typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_t;

    localparam logic [PIXEL_DATA_WIDTH-1:0] X_LAST = PIXEL_DATA_WIDTH'(FRAME_WIDTH - 1);
    localparam logic [PIXEL_DATA_WIDTH-1:0] Y_LAST = PIXEL_DATA_WIDTH'(FRAME_HEIGHT - 1);
    localparam logic [PIXEL_DATA_WIDTH-1:0] XY_ONE = PIXEL_DATA_WIDTH'(1);

    phase_t                      phase, phase_next;
    logic [PIXEL_DATA_WIDTH-1:0] x, y, x_next, y_next;
    logic [23:0]                 resid, resid_next, pixel;
    logic                        grp_first, grp_first_next;
    logic                        out_eof;
    logic                        accept, exp_first, exp_lx, exp_ly;
    logic                        mismatch, resync;
    logic                        emit, word_user, word_last;
    logic [31:0]                 word;

    // Phase 0 never emits, so it may take a pixel even while the output is stalled.
    assign bus.ready = !reset && (phase == PH0 || !bus.out_tvalid || bus.out_tready);

    always_ff @(posedge clk) begin
        if (reset) begin
            phase     <= PH0;
            x         <= '0;
            y         <= '0;
            resid     <= '0;
            grp_first <= 1'b0;
        end else begin
            phase     <= phase_next;
            x         <= x_next;
            y         <= y_next;
            resid     <= resid_next;
            grp_first <= grp_first_next;
        end
    end

    always_comb begin
        pixel          = {bus.b, bus.g, bus.r};
        accept         = bus.valid && bus.ready;
        exp_first      = (x == '0) && (y == '0);
        exp_lx         = (x == X_LAST);
        exp_ly         = exp_lx && (y == Y_LAST);
        mismatch       = accept && ((bus.first != exp_first) || (bus.last_x != exp_lx) ||
                                    (bus.last_y != exp_ly));
        resync         = accept && bus.first && !exp_first;
        phase_next     = phase;
        resid_next     = resid;
        grp_first_next = grp_first;
        x_next         = x;
        y_next         = y;
        emit           = 1'b0;
        word           = '0;
        word_user      = 1'b0;
        word_last      = 1'b0;

        if (resync) begin
            // Restart the frame at this pixel; any partial group is dropped.
            phase_next     = PH1;
            resid_next     = pixel;
            grp_first_next = 1'b1;
            x_next         = XY_ONE;
            y_next         = '0;
        end else if (accept) begin
            x_next = exp_lx ? '0 : x + XY_ONE;
            if (exp_lx)
                y_next = (y == Y_LAST) ? '0 : y + XY_ONE;
            unique case (phase)
                PH0: begin
                    resid_next     = pixel;
                    grp_first_next = exp_first;
                    phase_next     = PH1;
                end
                PH1: begin
                    emit       = 1'b1;
                    word       = {pixel[7:0], resid};
                    word_user  = grp_first;
                    resid_next = {8'd0, pixel[23:8]};
                    phase_next = PH2;
                end
                PH2: begin
                    emit       = 1'b1;
                    word       = {pixel[15:0], resid[15:0]};
                    resid_next = {16'd0, pixel[23:16]};
                    phase_next = PH3;
                end
                PH3: begin
                    emit       = 1'b1;
                    word       = {pixel, resid[7:0]};
                    word_last  = exp_lx;
                    phase_next = PH0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_tvalid <= 1'b0;
            bus.out_tdata  <= '0;
            bus.out_tuser  <= 1'b0;
            bus.out_tlast  <= 1'b0;
            out_eof        <= 1'b0;
            frame_done     <= 1'b0;
            frame_err      <= 1'b0;
            err_count      <= '0;
        end else begin
            if (emit) begin
                bus.out_tvalid <= 1'b1;
                bus.out_tdata  <= word;
                bus.out_tuser  <= word_user;
                bus.out_tlast  <= word_last;
                out_eof        <= word_last && (y == Y_LAST);
            end else if (bus.out_tready) begin
                bus.out_tvalid <= 1'b0;
            end
            frame_done <= bus.out_tvalid && bus.out_tready && out_eof;
            frame_err  <= mismatch;
            if (mismatch && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_rgb_stream_packer.sv
// tb/tb_rgb_stream_packer.sv - scoreboard bench for rgb_stream_packer
module tb_rgb_stream_packer;
    localparam int W = 8;
    localparam int H = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_done, frame_err;
    logic [7:0] err_count;

    rgb_stream_packer_if bus();

    rgb_stream_packer #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .PIXEL_DATA_WIDTH(10)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .frame_done(frame_done), .frame_err(frame_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [10:0] bq[$];   // byte stream: {eof, eol, sof, byte}
    logic [34:0] exq[$];  // expected word: {eof, tlast, tuser, tdata}
    int          mx = 0, my = 0, pix_k = 0, exp_err = 0;
    int          words_seen = 0, fd_seen = 0, ferr_seen = 0;
    bit          fd_expect = 1'b0;

    function automatic logic [23:0] pix_val(input int k);
        logic [7:0] a;
        a = 8'(3 * k + 1);
        return {a + 8'd2, a + 8'd1, a};
    endfunction

    // Reference: pixels become a little-endian byte stream, cut into 32-bit words.
    task automatic model_push(input logic [23:0] p, input bit resync);
        bit sof, eol, eof;
        logic [34:0] e;
        logic [10:0] bt;
        if (resync) begin
            bq.delete();
            mx = 0;
            my = 0;
        end
        sof = (mx == 0) && (my == 0);
        eol = (mx == W - 1);
        eof = eol && (my == H - 1);
        bq.push_back({2'b00, sof, p[7:0]});
        bq.push_back({3'b000, p[15:8]});
        bq.push_back({eof, eol, 1'b0, p[23:16]});
        while (bq.size() >= 4) begin
            e = '0;
            for (int i = 0; i < 4; i++) begin
                bt = bq.pop_front();
                e[8*i +: 8] = bt[7:0];
                e[32] = e[32] | bt[8];
                e[33] = e[33] | bt[9];
                e[34] = e[34] | bt[10];
            end
            exq.push_back(e);
        end
        if (eol) begin
            mx = 0;
            my = (my == H - 1) ? 0 : my + 1;
        end else begin
            mx++;
        end
    endtask

    task automatic send_pixel(input logic [23:0] p, input bit f, input bit lx, input bit ly,
                              input bit resync);
        int n = 0;
        bit ok = 1'b0;
        model_push(p, resync);
        bus.r = p[7:0];
        bus.g = p[15:8];
        bus.b = p[23:16];
        bus.first = f;
        bus.last_x = lx;
        bus.last_y = ly;
        bus.valid = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (bus.ready === 1'b1) ok = 1'b1;
            else n++;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL ready_timeout: ready=%b after %0d cycles, required 1", bus.ready, n);
        end
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
    endtask

    task automatic send_next(input int early_lx);
        bit f, lx, ly;
        f  = (mx == 0) && (my == 0);
        lx = (mx == W - 1) || ((mx == early_lx) && (my == 0));
        ly = (mx == W - 1) && (my == H - 1);
        send_pixel(pix_val(pix_k), f, lx, ly, 1'b0);
        pix_k++;
    endtask

    task automatic drain();
        int n = 0;
        bus.out_tready = 1'b1;
        while (exq.size() > 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (exq.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d words still expected, required 0", exq.size());
        end
    endtask

    task automatic monitor();
        logic [34:0] e;
        forever begin
            @(negedge clk);
            total++;
            if (frame_done !== fd_expect) begin
                bad++;
                $display("FAIL frame_done: got %b, required %b", frame_done, fd_expect);
            end
            fd_expect = 1'b0;
            if (frame_done === 1'b1) fd_seen++;
            if (frame_err === 1'b1) ferr_seen++;
            if (reset === 1'b0 && bus.out_tvalid === 1'b1 && bus.out_tready === 1'b1) begin
                total++;
                words_seen++;
                if (exq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_word: got %h, required none", bus.out_tdata);
                end else begin
                    e = exq.pop_front();
                    if ({bus.out_tlast, bus.out_tuser, bus.out_tdata} !== e[33:0]) begin
                        bad++;
                        $display("FAIL word: got last=%b user=%b data=%h, required last=%b user=%b data=%h",
                                 bus.out_tlast, bus.out_tuser, bus.out_tdata, e[33], e[32], e[31:0]);
                    end
                    fd_expect = e[34];
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.valid = 1'b0;
        bus.out_tready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus.ready, bus.out_tvalid, bus.out_tuser, bus.out_tlast, frame_done, frame_err} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b%b%b%b%b%b, required 000000", bus.ready, bus.out_tvalid,
                     bus.out_tuser, bus.out_tlast, frame_done, frame_err);
        end
        total++;
        if (bus.out_tdata !== 32'h0 || err_count !== 8'h0) begin
            bad++;
            $display("FAIL reset_values: got tdata=%h err=%0d, required 0 and 0", bus.out_tdata, err_count);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (bus.ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_reset: got %b, required 1", bus.ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_packing();
        logic [31:0] want[3];
        want[0] = 32'h04030201;
        want[1] = 32'h08070605;
        want[2] = 32'h0C0B0A09;
        pix_k = 0;
        bus.out_tready = 1'b1;
        send_next(-1);
        total++;
        if (bus.out_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL pack_phase0: tvalid=%b, required 0", bus.out_tvalid);
        end
        for (int i = 0; i < 3; i++) begin
            send_next(-1);
            total++;
            if (bus.out_tvalid !== 1'b1 || bus.out_tdata !== want[i]) begin
                bad++;
                $display("FAIL pack_word%0d: tvalid=%b data=%h, required 1 and %h", i,
                         bus.out_tvalid, bus.out_tdata, want[i]);
            end
        end
        for (int i = 4; i < 2 * W; i++) send_next(-1);
        drain();
    endtask

    task automatic test_full_frame();
        int w0 = words_seen, fd0 = fd_seen, fe0 = ferr_seen;
        for (int i = 0; i < W * H; i++) send_next(-1);
        drain();
        total++;
        if (words_seen - w0 != 12 || fd_seen - fd0 != 1) begin
            bad++;
            $display("FAIL full_frame: words=%0d done=%0d, required 12 and 1", words_seen - w0, fd_seen - fd0);
        end
        total++;
        if (err_count !== 8'(exp_err) || ferr_seen != fe0) begin
            bad++;
            $display("FAIL full_frame_err: err=%0d pulses=%0d, required %0d and 0", err_count,
                     ferr_seen - fe0, exp_err);
        end
    endtask

    task automatic test_back_to_back();
        time t0;
        t0 = $time;
        for (int i = 0; i < W * H; i++) send_next(-1);
        total++;
        if ($time - t0 != 160) begin
            bad++;
            $display("FAIL throughput: %0t for 16 pixels, required 160", $time - t0);
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [23:0] p0, p1;
        logic [31:0] held;
        p0 = pix_val(pix_k);
        p1 = pix_val(pix_k + 1);
        held = {p1[7:0], p0};
        send_next(-1);
        send_next(-1);
        bus.out_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (bus.out_tvalid !== 1'b1 || bus.out_tdata !== held || bus.ready !== 1'b0) begin
                bad++;
                $display("FAIL stall%0d: tvalid=%b data=%h ready=%b, required 1 %h 0", i,
                         bus.out_tvalid, bus.out_tdata, bus.ready, held);
            end
        end
        @(posedge clk);
        #1;
        bus.out_tready = 1'b1;
        for (int i = 2; i < W * H; i++) send_next(-1);
        drain();
    endtask

    task automatic test_early_last_x();
        int fe0 = ferr_seen;
        for (int i = 0; i < W * H; i++) send_next(5);
        exp_err++;
        drain();
        total++;
        if (ferr_seen - fe0 != 1 || err_count !== 8'(exp_err)) begin
            bad++;
            $display("FAIL early_last_x: pulses=%0d err=%0d, required 1 and %0d", ferr_seen - fe0,
                     err_count, exp_err);
        end
    endtask

    task automatic test_resync();
        int fe0 = ferr_seen, fd0 = fd_seen;
        logic [23:0] ps, pn;
        for (int i = 0; i < 6; i++) send_next(-1);
        ps = pix_val(pix_k);
        send_pixel(ps, 1'b1, 1'b0, 1'b0, 1'b1);
        pix_k++;
        exp_err++;
        pn = pix_val(pix_k);
        send_next(-1);
        total++;
        if (bus.out_tvalid !== 1'b1 || bus.out_tuser !== 1'b1 || bus.out_tdata !== {pn[7:0], ps}) begin
            bad++;
            $display("FAIL resync_word: tvalid=%b user=%b data=%h, required 1 1 %h", bus.out_tvalid,
                     bus.out_tuser, bus.out_tdata, {pn[7:0], ps});
        end
        for (int i = 2; i < W * H; i++) send_next(-1);
        drain();
        total++;
        if (ferr_seen - fe0 != 1 || err_count !== 8'(exp_err) || fd_seen - fd0 != 1) begin
            bad++;
            $display("FAIL resync_err: pulses=%0d err=%0d done=%0d, required 1 %0d 1", ferr_seen - fe0,
                     err_count, fd_seen - fd0, exp_err);
        end
    endtask

    task automatic test_reset_mid_frame();
        int fd0;
        for (int i = 0; i < 3; i++) send_next(-1);
        bus.out_tready = 1'b0;
        @(negedge clk);
        total++;
        if (bus.out_tvalid !== 1'b1) begin
            bad++;
            $display("FAIL pending_before_reset: tvalid=%b, required 1", bus.out_tvalid);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (bus.ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_in_reset: got %b, required 0", bus.ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        bq.delete();
        exq.delete();
        mx = 0;
        my = 0;
        exp_err = 0;
        @(negedge clk);
        total++;
        if (bus.out_tvalid !== 1'b0 || err_count !== 8'h0) begin
            bad++;
            $display("FAIL after_reset: tvalid=%b err=%0d, required 0 and 0", bus.out_tvalid, err_count);
        end
        @(posedge clk);
        #1;
        bus.out_tready = 1'b1;
        fd0 = fd_seen;
        for (int i = 0; i < W * H; i++) send_next(-1);
        drain();
        total++;
        if (fd_seen - fd0 != 1 || err_count !== 8'h0) begin
            bad++;
            $display("FAIL fresh_frame: done=%0d err=%0d, required 1 and 0", fd_seen - fd0, err_count);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.valid = 1'b0;
        bus.r = '0;
        bus.g = '0;
        bus.b = '0;
        bus.first = 1'b0;
        bus.last_x = 1'b0;
        bus.last_y = 1'b0;
        bus.out_tready = 1'b1;
        test_reset();
        fork
            monitor();
        join_none
        test_packing();
        test_full_frame();
        test_back_to_back();
        test_backpressure();
        test_early_last_x();
        test_resync();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
